// File: rtl/seq_serial_adder.sv
// Bit-serial adder: WIDTH-cycle LSB-first add with carry, cout and ovf.
// Optional subtract mode via `define SERIAL_ADDER_SUB_EN (adds port sub).
module seq_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // One full-adder slice on the current LSBs and the running carry
    always_comb begin
        bit_s = a_q[0] ^ b_q[0] ^ c_q;
        bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    // Operand/carry values captured on the accepting edge
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Next-state and datapath update for IDLE/RUN/DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    c_d     = c_load;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {bit_s, acc_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = bit_c;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // c_q is the carry into the MSB on this step
                    sum_d   = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    ovf_d   = c_q ^ bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status decoded from the state register; results straight from flops
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule
